serial_mult_ctrl: RTL and testbench
===================================

# serial_mult_ctrl

Sequencer that computes an unsigned A_W×B_W product (default 4×3) by time-sharing one `full_adder` instance bit-serially across all partial-product additions. It latches operands on a start request, walks the shift-and-add schedule one product bit per clock, and returns the product with a one-cycle done pulse. It is the area-minimal alternative to the fully combinational 4×3 array multiplier in the same design directory.

## Interface
- `A_W`, default 4: multiplicand width.
- `B_W`, default 3: multiplier width; product width `P_W = A_W + B_W`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; accepted only when `busy` = 0.
- `a`  in  A_W  multiplicand, sampled on the accepting edge only.
- `b`  in  B_W  multiplier, sampled on the accepting edge only.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle onward.
- `product`  out  P_W  result register; holds until the next accepted start.

## Operation
- Exactly one `full_adder` instance performs every bit addition; no other adder in the block.
- Internal registers: `a_q`, `b_q`, accumulator `P` (P_W), `row` (0..B_W-1), `bitc` (0..A_W), `carry_q`.
- IDLE: on `start`=1, latch `a_q`←a, `b_q`←b, `P`←0, `row`←0, `bitc`←0, `carry_q`←0 → ADD.
- ADD, each cycle: `k = row + bitc`; full_adder inputs A=`P[k]`, B=(`bitc` < A_W) ? `a_q[bitc] & b_q[row]` : 0, C=`carry_q`; `P[k]`←sum, `carry_q`←carry, `bitc`←`bitc`+1.
- End of row (`bitc` = A_W): `bitc`←0, `carry_q`←0; if `row` = B_W-1 → DONE, else `row`←`row`+1.
- `k` never exceeds P_W-1; final carry out of the last bit of each row is provably 0 and is discarded.
- DONE: `product`←`P`, `done`=1 for this cycle only, → IDLE.
- `start` in ADD or DONE ignored (not queued). `a`/`b` changes after acceptance have no effect.
- Reset (`rst_n`=0 at a rising edge), including mid-operation: state IDLE, `busy`=0, `done`=0, `product`=0, all internal registers 0; operation in flight abandoned.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0.
- Accepting edge = cycle 0; `busy` high from cycle 1.
- Default (macro absent): ADD lasts B_W×(A_W+1) cycles = 15; DONE in cycle 16 (`done`=1, `product` valid); `busy` low and new start acceptable from cycle 17.
- Latency formula: `done` asserted B_W×(A_W+1)+1 cycles after the accepting edge.
- Back-to-back: `start` held high continuously yields one operation every 17 cycles.

## Configuration
- `SERIAL_MULT_SKIP_ZERO_ROW_EN` defined: in ADD, when `bitc` = 0 and `b_q[row]` = 0, the row completes in one cycle (no adder use, `P` unchanged, row advance as above). Latency becomes 1 + Σ(rows: 5 if bit set, 1 if clear) cycles to `done`; `product` identical to default.
- Undefined: every row takes A_W+1 cycles regardless of `b`; latency fixed at 16.

## Test plan
- Reset then idle: `rst_n`=0 two cycles → `busy`=0, `done`=0, `product`=0; no activity while `start`=0.
- a=9, b=5, start one cycle → `done` exactly 16 cycles later, `product`=45 (7'b0101101), `busy` low next cycle.
- Exhaustive 4×3 sweep (128 pairs), start re-asserted after each done → every `product` = a×b; max case 15×7=105 (7'b1101001); 0×7 and 15×0 = 0.
- a=3, b=2 accepted, then `start` pulsed with a=15, b=7 at cycle 5 → ignored; `product`=6 at cycle 16.
- a=15, b=7 accepted, `rst_n`=0 at cycle 8 → next cycle `busy`=0, `product`=0, no `done` pulse; fresh start after release gives 105 at +16.
- With `SERIAL_MULT_SKIP_ZERO_ROW_EN`: a=13, b=4 → `done` 8 cycles after accept, `product`=52; b=0 → `done` at +4, `product`=0.

Source files
------------

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-and-add multiplier sharing one full_adder across all partial-product bits.
// Optional build macro SERIAL_MULT_SKIP_ZERO_ROW_EN lets rows with a zero multiplier bit finish in one cycle.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_mult_ctrl #(
  parameter int unsigned A_W = 4,
  parameter int unsigned B_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned RW  = (B_W > 1) ? $clog2(B_W) : 1;
  localparam int unsigned CW  = $clog2(A_W + 1);
  localparam int unsigned KW  = (P_W > 1) ? $clog2(P_W) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [P_W-1:0] p_q, p_d;
  logic [P_W-1:0] product_q, product_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  bitc_q, bitc_d;
  logic           carry_q, carry_d;

  logic [KW-1:0]  k;
  logic           fa_a, fa_b, fa_sum, fa_cout;
  logic           row_end;

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Adder operands for the current schedule position; the column past the
  // multiplicand MSB only propagates the carry into P.
  always_comb begin
    k    = KW'(row_q) + KW'(bitc_q);
    fa_a = p_q[k];
    fa_b = 1'b0;
    if (bitc_q < CW'(A_W)) begin
      fa_b = a_q[bitc_q] & b_q[row_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    product_d = product_q;
    row_d     = row_q;
    bitc_d    = bitc_q;
    carry_d   = carry_q;
    row_end   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          p_d     = '0;
          row_d   = '0;
          bitc_d  = '0;
          carry_d = 1'b0;
          state_d = StAdd;
        end
      end

      StAdd: begin
`ifdef SERIAL_MULT_SKIP_ZERO_ROW_EN
        if ((bitc_q == '0) && !b_q[row_q]) begin
          row_end = 1'b1;
        end else begin
          p_d[k]  = fa_sum;
          carry_d = fa_cout;
          bitc_d  = bitc_q + CW'(1);
          row_end = (bitc_q == CW'(A_W));
        end
`else
        p_d[k]  = fa_sum;
        carry_d = fa_cout;
        bitc_d  = bitc_q + CW'(1);
        row_end = (bitc_q == CW'(A_W));
`endif
        if (row_end) begin
          bitc_d  = '0;
          carry_d = 1'b0;
          if (row_q == RW'(B_W - 1)) begin
            // Load the result on entry to DONE so it is visible during the done pulse.
            product_d = p_d;
            state_d   = StDone;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
      row_q     <= '0;
      bitc_q    <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      product_q <= product_d;
      row_q     <= row_d;
      bitc_q    <= bitc_d;
      carry_q   <= carry_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Directed, table-driven bench for serial_mult_ctrl (4x3 default build).

module tb_serial_mult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [6:0] product;

  int checks;
  int errors;

  serial_mult_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [2:0] b;
    logic [6:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] bv);
    int l;
`ifdef SERIAL_MULT_SKIP_ZERO_ROW_EN
    l = 1;
    for (int i = 0; i < 3; i++) l += bv[i] ? 5 : 1;
`else
    l = 16;
`endif
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the DUT idle; returns the cycle of done (-1 on timeout).
  task automatic run_op(input logic [3:0] av, input logic [2:0] bv,
                        output int lat, output int prod, output int busy1);
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = -1;
    prod  = -1;
    busy1 = int'(busy);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (done) begin
        lat  = c;
        prod = int'(product);
      end else begin
        step();
      end
    end
  endtask

  task automatic op_and_check(input string tag, input logic [3:0] av, input logic [2:0] bv,
                              input int exp_prod);
    int lat, prod, busy1;
    run_op(av, bv, lat, prod, busy1);
    check({tag, " latency"}, lat, exp_lat(bv));
    check({tag, " product"}, prod, exp_prod);
    if (lat >= 0) begin
      step();
      check({tag, " done pulse width"}, int'(done), 0);
      check({tag, " busy after done"}, int'(busy), 0);
    end
  endtask

  initial begin
    int lat, prod, busy1, t1, t2;
    checks = 0;
    errors = 0;

    vecs[0] = '{a: 4'd9,  b: 3'd5, prod: 7'd45};
    vecs[1] = '{a: 4'd15, b: 3'd7, prod: 7'd105};
    vecs[2] = '{a: 4'd0,  b: 3'd7, prod: 7'd0};
    vecs[3] = '{a: 4'd15, b: 3'd0, prod: 7'd0};
    vecs[4] = '{a: 4'd3,  b: 3'd2, prod: 7'd6};
    vecs[5] = '{a: 4'd13, b: 3'd4, prod: 7'd52};
    vecs[6] = '{a: 4'd1,  b: 3'd1, prod: 7'd1};
    vecs[7] = '{a: 4'd7,  b: 3'd3, prod: 7'd21};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset product", int'(product), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle busy", int'(busy), 0);
      check("idle done", int'(done), 0);
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, prod, busy1);
      check("vec busy at cycle 1", busy1, 1);
      check("vec latency", lat, exp_lat(vecs[i].b));
      check("vec product", prod, int'(vecs[i].prod));
      step();
      check("vec done low after pulse", int'(done), 0);
      check("vec busy low after done", int'(busy), 0);
    end

    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        op_and_check("sweep", 4'(ai), 3'(bi), ai * bi);
      end
    end

    // Start pulse mid-operation with new operands must be ignored.
    a     = 4'd3;
    b     = 3'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = -1;
    prod  = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (c == 5) begin
        a     = 4'd15;
        b     = 3'd7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat  = c;
        prod = int'(product);
      end else begin
        step();
      end
    end
    start = 1'b0;
    check("ignored start latency", lat, exp_lat(3'd2));
    check("ignored start product", prod, 6);
    step();
    step();
    check("ignored start not queued", int'(busy), 0);

    // Reset in the middle of an operation.
    op_and_check("pre-reset", 4'd15, 3'd7, 105);
    a     = 4'd15;
    b     = 3'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    check("mid-op busy before reset", int'(busy), 1);
    rst_n = 1'b0;
    step();
    check("mid-op reset busy", int'(busy), 0);
    check("mid-op reset product", int'(product), 0);
    check("mid-op reset done", int'(done), 0);
    step();
    check("reset held done", int'(done), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) check("no done after abandoned op", int'(done), 0);
    end
    op_and_check("post-reset", 4'd15, 3'd7, 105);

    // Start held high: one operation per exp_lat+1 cycles.
    a     = 4'd9;
    b     = 3'd5;
    start = 1'b1;
    t1    = -1;
    t2    = -1;
    for (int c = 0; c < 80 && t2 < 0; c++) begin
      step();
      if (done) begin
        check("back-to-back product", int'(product), 45);
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
    end
    start = 1'b0;
    check("back-to-back period", (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1, exp_lat(3'd5) + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
